// File: rtl/p2p_cfg_reg_axil_pkg.sv
// Shared types and register map for the P2P filter configuration slave.
// Each rule spans six words: ipv4, ipv6[127:96]..ipv6[31:0], {flags, proto, port}.
package p2p_cfg_reg_axil_pkg;

  localparam int NUM_REGS    = 16;
  localparam int NUM_RULES   = 2;
  localparam int RULE_WORDS  = 6;
  localparam int NUM_RW_REGS = NUM_RULES * RULE_WORDS;

  typedef logic [3:0] reg_idx_t;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  localparam reg_idx_t RULE_FIRST_RO = 4'hC;
  localparam reg_idx_t RULE1_FIRST   = 4'h6;

  localparam int RULE_OFF_IPV4 = 0;
  localparam int RULE_OFF_IPV6 = 1;
  localparam int RULE_OFF_PORT = 5;

  typedef struct packed {
    logic [7:0]   flags;
    logic [7:0]   proto;
    logic [15:0]  port;
    logic [127:0] ipv6_addr;
    logic [31:0]  ipv4_addr;
  } rule_t;

  typedef struct packed {
    rule_t [NUM_RULES-1:0] rule;
  } cfg_reg_t;

  typedef struct packed {
    logic [31:0] dropped_packets;
    logic [31:0] total_packets;
    logic [31:0] matched_rule1;
    logic [31:0] matched_rule0;
  } status_reg_t;

  // Status words 0xC..0xF: matched_rule0, matched_rule1, total_packets, dropped_packets.
  function automatic logic [31:0] status_word(status_reg_t s, logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = s.matched_rule0;
      2'd1:    w = s.matched_rule1;
      2'd2:    w = s.total_packets;
      default: w = s.dropped_packets;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/p2p_cfg_reg_axil_wr_join.sv
// Captures AXI-Lite AW and W beats independently, joins them into a single
// commit pulse and owns the B channel. One outstanding write at a time.
module p2p_axil_wr_join
  import p2p_cfg_reg_axil_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axil_awvalid,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  output logic              s_axil_awready,
  input  logic              s_axil_wvalid,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  output logic              s_axil_wready,
  output logic              s_axil_bvalid,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_bready,
  output logic              wr_commit,
  output reg_idx_t          wr_idx,
  output logic              wr_in_range,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb
);

  logic aw_got;
  logic w_got;
  logic aw_hs;
  logic w_hs;
  logic aw_in_range;
  logic range_now;
  logic unused_aw_lsb;

  assign aw_hs         = s_axil_awvalid && s_axil_awready;
  assign w_hs          = s_axil_wvalid && s_axil_wready;
  assign aw_in_range   = (s_axil_awaddr[ADDR_W-1:6] == '0);
  assign range_now     = aw_hs ? aw_in_range : wr_in_range;
  assign unused_aw_lsb = ^s_axil_awaddr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= AXIL_RESP_OKAY;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      wr_commit      <= 1'b0;
      wr_idx         <= '0;
      wr_in_range    <= 1'b0;
      wr_data        <= '0;
      wr_strb        <= '0;
    end else begin
      wr_commit <= 1'b0;
      if (s_axil_bvalid) begin
        if (s_axil_bready) begin
          s_axil_bvalid  <= 1'b0;
          aw_got         <= 1'b0;
          w_got          <= 1'b0;
          s_axil_awready <= 1'b1;
          s_axil_wready  <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          aw_got         <= 1'b1;
          s_axil_awready <= 1'b0;
          wr_idx         <= s_axil_awaddr[5:2];
          wr_in_range    <= aw_in_range;
        end else if (!aw_got) begin
          s_axil_awready <= 1'b1;
        end
        if (w_hs) begin
          w_got         <= 1'b1;
          s_axil_wready <= 1'b0;
          wr_data       <= s_axil_wdata;
          wr_strb       <= s_axil_wstrb;
        end else if (!w_got) begin
          s_axil_wready <= 1'b1;
        end
        // Last beat lands: the following cycle is the commit cycle, with B already up.
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          s_axil_bvalid <= 1'b1;
          wr_commit     <= 1'b1;
          s_axil_bresp  <= range_now ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: rtl/p2p_cfg_reg_axil.sv
// AXI4-Lite register slave holding the P2P filter rule set and exposing the
// filter's live status counters for readback.
module p2p_cfg_reg_axil
  import p2p_cfg_reg_axil_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                          axil_aclk,
  input  logic                          axil_rst,
  input  logic                          s_axil_awvalid,
  input  logic [ADDR_W-1:0]             s_axil_awaddr,
  output logic                          s_axil_awready,
  input  logic                          s_axil_wvalid,
  input  logic [31:0]                   s_axil_wdata,
  input  logic [3:0]                    s_axil_wstrb,
  output logic                          s_axil_wready,
  output logic                          s_axil_bvalid,
  output logic [1:0]                    s_axil_bresp,
  input  logic                          s_axil_bready,
  input  logic                          s_axil_arvalid,
  input  logic [ADDR_W-1:0]             s_axil_araddr,
  output logic                          s_axil_arready,
  output logic                          s_axil_rvalid,
  output logic [31:0]                   s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  input  logic                          s_axil_rready,
  output logic [$bits(cfg_reg_t)-1:0]   cfg_reg_o,
  input  logic [$bits(status_reg_t)-1:0] status_i,
  output logic                          cfg_upd_o,
  output logic                          cfg_upd_rule_o
);

  logic        wr_commit;
  reg_idx_t    wr_idx;
  logic        wr_in_range;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_rw;

  logic [31:0] regs [NUM_RW_REGS];
  cfg_reg_t    cfg_w;

  reg_idx_t    rd_idx;
  logic        rd_in_range;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        unused_ar_lsb;

  p2p_axil_wr_join #(
    .ADDR_W(ADDR_W)
  ) u_wr_join (
    .clk            (axil_aclk),
    .rst            (axil_rst),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awready (s_axil_awready),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bready  (s_axil_bready),
    .wr_commit      (wr_commit),
    .wr_idx         (wr_idx),
    .wr_in_range    (wr_in_range),
    .wr_data        (wr_data),
    .wr_strb        (wr_strb)
  );

  assign wr_rw = wr_in_range && (wr_idx < RULE_FIRST_RO);

  always_ff @(posedge axil_aclk or posedge axil_rst) begin
    if (axil_rst) begin
      for (int i = 0; i < NUM_RW_REGS; i++) regs[i] <= '0;
      cfg_upd_o      <= 1'b0;
      cfg_upd_rule_o <= 1'b0;
    end else begin
      cfg_upd_o <= 1'b0;
      if (wr_commit && wr_rw) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
        cfg_upd_o      <= 1'b1;
        cfg_upd_rule_o <= (wr_idx >= RULE1_FIRST);
      end
    end
  end

  for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
    localparam int B = r * RULE_WORDS;
    assign cfg_w.rule[r] = {regs[B+RULE_OFF_PORT],
                            regs[B+RULE_OFF_IPV6],   regs[B+RULE_OFF_IPV6+1],
                            regs[B+RULE_OFF_IPV6+2], regs[B+RULE_OFF_IPV6+3],
                            regs[B+RULE_OFF_IPV4]};
  end

  assign cfg_reg_o = cfg_w;

  assign rd_idx        = s_axil_araddr[5:2];
  assign rd_in_range   = (s_axil_araddr[ADDR_W-1:6] == '0);
  assign unused_ar_lsb = ^s_axil_araddr[1:0];

  // Read mux sees the pre-commit register contents, so a read in the commit cycle returns old data.
  always_comb begin
    rd_word = '0;
    rd_resp = AXIL_RESP_OKAY;
    if (!rd_in_range) begin
      rd_resp = AXIL_RESP_SLVERR;
    end else if (rd_idx < RULE_FIRST_RO) begin
      rd_word = regs[rd_idx];
    end else begin
      rd_word = status_word(status_reg_t'(status_i), rd_idx[1:0]);
    end
  end

  always_ff @(posedge axil_aclk or posedge axil_rst) begin
    if (axil_rst) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= AXIL_RESP_OKAY;
    end else if (s_axil_rvalid) begin
      if (s_axil_rready) begin
        s_axil_rvalid  <= 1'b0;
        s_axil_arready <= 1'b1;
      end
    end else if (s_axil_arready && s_axil_arvalid) begin
      s_axil_rvalid  <= 1'b1;
      s_axil_arready <= 1'b0;
      s_axil_rdata   <= rd_word;
      s_axil_rresp   <= rd_resp;
    end else begin
      s_axil_arready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_p2p_cfg_reg_axil.sv
// Scoreboard bench for p2p_cfg_reg_axil: drivers push expected B/R/update events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_p2p_cfg_reg_axil;
  import p2p_cfg_reg_axil_pkg::*;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  cfg_reg_t          cfg;
  status_reg_t       status;
  logic              cfg_upd, cfg_upd_rule;

  always #5 clk = ~clk;

  p2p_cfg_reg_axil #(.ADDR_W(ADDR_W)) dut (
    .axil_aclk(clk), .axil_rst(rst),
    .s_axil_awvalid(awvalid), .s_axil_awaddr(awaddr), .s_axil_awready(awready),
    .s_axil_wvalid(wvalid), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wready(wready),
    .s_axil_bvalid(bvalid), .s_axil_bresp(bresp), .s_axil_bready(bready),
    .s_axil_arvalid(arvalid), .s_axil_araddr(araddr), .s_axil_arready(arready),
    .s_axil_rvalid(rvalid), .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rready(rready),
    .cfg_reg_o(cfg), .status_i(status), .cfg_upd_o(cfg_upd), .cfg_upd_rule_o(cfg_upd_rule)
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model [12];
  logic [1:0]  bq [$];
  rexp_t       rq [$];
  logic        uq [$];
  bit          rand_ready = 0;
  bit          rand_status = 0;

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s actual=missing required=event", name);
  endtask

  // Reference model: byte-strobed words 0x0-0xB, read-only status 0xC-0xF, SLVERR beyond.
  function automatic logic [1:0] model_write(logic [11:0] a, logic [31:0] d, logic [3:0] s);
    int idx;
    if (a[11:6] != 0) return AXIL_RESP_SLVERR;
    idx = int'(a[5:2]);
    if (idx < 12) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      uq.push_back(idx >= 6);
    end
    return AXIL_RESP_OKAY;
  endfunction

  function automatic rexp_t model_read(logic [11:0] a);
    rexp_t r;
    int idx;
    r.data = 0;
    r.resp = AXIL_RESP_OKAY;
    idx = int'(a[5:2]);
    if (a[11:6] != 0) r.resp = AXIL_RESP_SLVERR;
    else if (idx < 12) r.data = model[idx];
    else if (idx == 12) r.data = status.matched_rule0;
    else if (idx == 13) r.data = status.matched_rule1;
    else if (idx == 14) r.data = status.total_packets;
    else r.data = status.dropped_packets;
    return r;
  endfunction

  function automatic cfg_reg_t exp_cfg();
    cfg_reg_t e;
    for (int r = 0; r < 2; r++) begin
      e.rule[r].ipv4_addr = model[r*6];
      e.rule[r].ipv6_addr = {model[r*6+1], model[r*6+2], model[r*6+3], model[r*6+4]};
      e.rule[r].port      = model[r*6+5][15:0];
      e.rule[r].proto     = model[r*6+5][23:16];
      e.rule[r].flags     = model[r*6+5][31:24];
    end
    return e;
  endfunction

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else check("bresp", bresp, bq.pop_front());
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) fail_now("r_unexpected");
        else begin
          rexp_t e;
          e = rq.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", rresp, e.resp);
        end
      end
      if (cfg_upd) begin
        if (uq.size() == 0) fail_now("upd_unexpected");
        else check("upd_rule", cfg_upd_rule, uq.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) begin
      bready = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
    end
    if (rand_status) status = {$urandom, $urandom, $urandom, $urandom};
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_b();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < 200);
    if (!(bvalid && bready)) fail_now("b_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(rvalid && rready) && n < 200);
    if (!(rvalid && rready)) fail_now("r_timeout");
    @(posedge clk); #1;
  endtask

  task automatic do_write(logic [11:0] a, logic [31:0] d, logic [3:0] s, int awd, int wd);
    bq.push_back(model_write(a, d, s));
    fork
      begin
        int n = 0;
        repeat (awd) begin @(posedge clk); #1; end
        awvalid = 1'b1; awaddr = a;
        do begin @(negedge clk); n++; end while (!awready && n < 100);
        if (!awready) fail_now("aw_timeout");
        @(posedge clk); #1;
        awvalid = 1'b0;
      end
      begin
        int n = 0;
        repeat (wd) begin @(posedge clk); #1; end
        wvalid = 1'b1; wdata = d; wstrb = s;
        do begin @(negedge clk); n++; end while (!wready && n < 100);
        if (!wready) fail_now("w_timeout");
        @(posedge clk); #1;
        wvalid = 1'b0;
      end
    join
    check("b_latency", bvalid, 1'b1);
    wait_b();
  endtask

  task automatic do_read(logic [11:0] a);
    int n = 0;
    arvalid = 1'b1; araddr = a;
    do begin @(negedge clk); n++; end while (!arready && n < 100);
    if (!arready) fail_now("ar_timeout");
    rq.push_back(model_read(a));
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_r();
  endtask

  initial begin
    rexp_t old;
    int n;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; status = '0;
    for (int i = 0; i < 12; i++) model[i] = 0;

    repeat (2) @(negedge clk);
    check("rst_cfg", cfg, '0);
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid, cfg_upd, cfg_upd_rule}, 4'b0000);
    check("rst_resp_data", {bresp, rresp, rdata}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    bready = 1'b1; rready = 1'b1;
    do_read(12'h000);

    // AW first, W two cycles later
    do_write(12'h014, 32'h0000_1F90, 4'hF, 0, 2);
    check("rule0_port", cfg.rule[0].port, 16'h1F90);

    do_write(12'h004, 32'hFFFF_FFFF, 4'hF, 1, 0);
    do_write(12'h004, 32'h2001_0DB8, 4'b0011, 0, 0);
    check("ipv6_hi_strb", cfg.rule[0].ipv6_addr[127:96], 32'hFFFF_0DB8);
    do_write(12'h008, 32'hDEAD_BEEF, 4'h0, 0, 1);
    check("strb_zero_cfg", cfg, exp_cfg());

    // Status read held off by rready
    status.total_packets = 32'h55;
    rready = 1'b0;
    arvalid = 1'b1; araddr = 12'h038;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 100);
    rq.push_back('{data: 32'h55, resp: AXIL_RESP_OKAY});
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (5) begin
      status.total_packets = $urandom | 32'h100;
      @(negedge clk);
      check("hold_rvalid", rvalid, 1'b1);
      check("hold_rdata", rdata, 32'h55);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_r();
    check("rvalid_drop", rvalid, 1'b0);

    do_write(12'h030, 32'h1234_5678, 4'hF, 0, 0);
    check("ro_write_cfg", cfg, exp_cfg());
    do_read(12'h030);
    do_write(12'h040, 32'hCAFE_F00D, 4'hF, 2, 0);
    do_read(12'h040);
    check("oor_cfg", cfg, exp_cfg());

    // Read in the commit cycle sees the old value
    do_write(12'h018, 32'h1234_5678, 4'hF, 0, 0);
    old = model_read(12'h018);
    awvalid = 1'b1; awaddr = 12'h018; wvalid = 1'b1; wdata = 32'h0A00_0001; wstrb = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 100);
    bq.push_back(model_write(12'h018, 32'h0A00_0001, 4'hF));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("commit_bvalid", bvalid, 1'b1);
    arvalid = 1'b1; araddr = 12'h018;
    @(negedge clk);
    check("commit_arready", arready, 1'b1);
    rq.push_back(old);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_r();
    do_read(12'h018);
    check("rule1_ipv4", cfg.rule[1].ipv4_addr, 32'h0A00_0001);

    // Randomized traffic
    rand_ready = 1;
    rand_status = 1;
    for (int t = 0; t < 300; t++) begin
      logic [11:0] a;
      if ($urandom_range(0, 9) == 0) a = {6'($urandom_range(1, 63)), 6'($urandom)};
      else a = {6'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        check("cfg_model", cfg, exp_cfg());
      end else begin
        do_read(a);
      end
    end

    rand_ready = 0;
    rand_status = 0;
    @(posedge clk); #1;
    bready = 1'b1; rready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("bq_empty", bq.size(), 0);
    check("rq_empty", rq.size(), 0);
    check("uq_empty", uq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
